atmega_exint: RTL and testbench

- ATmega-style external interrupt controller. It sits directly downstream of atmega_pio.
- Consumes the same pad inputs that the PIO samples into PIN. Synchronises them and detects level/edge events per pin according to EICRA/EICRB sense bits. Latches events into EIFR and raises per-pin requests gated by EIMSK toward the core interrupt arbiter.
- Registers are accessed over the same addr/wr/rd bus as atmega_pio.

---
 rtl/atmega_exint_pkg.sv | 24 ++
 rtl/atmega_exint_sync.sv | 32 +++
 rtl/atmega_exint.sv | 110 +++++++++++
 tb/tb_atmega_exint.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/atmega_exint_pkg.sv
// Shared definitions for the ATmega-style external interrupt controller.
package atmega_exint_pkg;

    localparam logic [1:0] ISC_LOW  = 2'b00;
    localparam logic [1:0] ISC_ANY  = 2'b01;
    localparam logic [1:0] ISC_FALL = 2'b10;
    localparam logic [1:0] ISC_RISE = 2'b11;

    localparam int unsigned DEF_EICRA_ADDR = 'h69;
    localparam int unsigned DEF_EICRB_ADDR = 'h6A;
    localparam int unsigned DEF_EIMSK_ADDR = 'h3D;
    localparam int unsigned DEF_EIFR_ADDR  = 'h3C;

    // Expand a 4-pin implemented mask into the matching 2-bit-per-pin sense-control mask.
    function automatic logic [7:0] isc_mask(input logic [3:0] pins);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 4; i++) begin
            m[2*i +: 2] = {2{pins[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/atmega_exint_sync.sv
// One-pin pad synchroniser with a previous-sample register and edge outputs.
module atmega_exint_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad,
    output logic sync,
    output logic rise_c,
    output logic fall_c,
    output logic change_c
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pad};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync     = chain[SYNC_STAGES-1];
    assign rise_c   = sync & ~prev;
    assign fall_c   = ~sync & prev;
    assign change_c = sync ^ prev;

endmodule

// File: rtl/atmega_exint.sv
// External interrupt controller: per-pin sense control, W1C flags and masked requests.
module atmega_exint
    import atmega_exint_pkg::*;
#(
    parameter int unsigned BUS_ADDR_DATA_LEN = 8,
    parameter int unsigned PORT_WIDTH        = 8,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned EICRA_ADDR        = DEF_EICRA_ADDR,
    parameter int unsigned EICRB_ADDR        = DEF_EICRB_ADDR,
    parameter int unsigned EIMSK_ADDR        = DEF_EIMSK_ADDR,
    parameter int unsigned EIFR_ADDR         = DEF_EIFR_ADDR,
    parameter logic [7:0]  PINMASK           = 8'hFF
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
    input  logic                         wr_i,
    input  logic                         rd_i,
    input  logic [7:0]                   bus_i,
    output logic [7:0]                   bus_o,
    input  logic [PORT_WIDTH-1:0]        pins_i,
    output logic [PORT_WIDTH-1:0]        int_o,
    input  logic [PORT_WIDTH-1:0]        int_ack_i
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1);
    localparam logic [7:0]  IMPL  = PINMASK & 8'((1 << PORT_WIDTH) - 1);
    localparam logic [7:0]  EICRA_WMASK = isc_mask(IMPL[3:0]);
    localparam logic [7:0]  EICRB_WMASK = isc_mask(IMPL[7:4]);

    localparam logic [BUS_ADDR_DATA_LEN-1:0] A_EICRA = BUS_ADDR_DATA_LEN'(EICRA_ADDR);
    localparam logic [BUS_ADDR_DATA_LEN-1:0] A_EICRB = BUS_ADDR_DATA_LEN'(EICRB_ADDR);
    localparam logic [BUS_ADDR_DATA_LEN-1:0] A_EIMSK = BUS_ADDR_DATA_LEN'(EIMSK_ADDR);
    localparam logic [BUS_ADDR_DATA_LEN-1:0] A_EIFR  = BUS_ADDR_DATA_LEN'(EIFR_ADDR);

    logic [7:0]            eicra, eicrb, eimsk, eifr;
    logic [7:0]            eifr_clr, eifr_nxt;
    logic [CNT_W-1:0]      settle_cnt;
    logic                  armed;
    logic                  edge_armed;
    logic [PORT_WIDTH-1:0] sync_w, evt_w, low_w;

    assign armed = (settle_cnt == CNT_W'(SYNC_STAGES));

    // prev only holds a real sample one cycle after s does, so edges arm one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            settle_cnt <= '0;
            edge_armed <= 1'b0;
            eicra      <= 8'h00;
            eicrb      <= 8'h00;
            eimsk      <= 8'h00;
            eifr       <= 8'h00;
        end else begin
            if (!armed) settle_cnt <= settle_cnt + CNT_W'(1);
            edge_armed <= armed;
            if (wr_i && addr_i == A_EICRA) eicra <= bus_i & EICRA_WMASK;
            if (wr_i && addr_i == A_EICRB) eicrb <= bus_i & EICRB_WMASK;
            if (wr_i && addr_i == A_EIMSK) eimsk <= bus_i & IMPL;
            eifr <= eifr_nxt;
        end
    end

    // Set wins over a same-cycle clear so no event is lost.
    always_comb begin
        eifr_clr = ((wr_i && addr_i == A_EIFR) ? bus_i : 8'h00) | 8'(int_ack_i);
        eifr_nxt = ((eifr & ~eifr_clr) | 8'(evt_w)) & IMPL;
    end

    for (genvar n = 0; n < PORT_WIDTH; n++) begin : g_pin
        logic [1:0] isc;
        logic       rise, fall, change;

        if (n < 4) begin : g_lo
            assign isc = eicra[2*n +: 2];
        end else begin : g_hi
            assign isc = eicrb[2*(n-4) +: 2];
        end

        atmega_exint_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .pad      (pins_i[n]),
            .sync     (sync_w[n]),
            .rise_c   (rise),
            .fall_c   (fall),
            .change_c (change)
        );

        assign evt_w[n] = IMPL[n] & edge_armed &
                          (((isc == ISC_ANY)  & change) |
                           ((isc == ISC_FALL) & fall)   |
                           ((isc == ISC_RISE) & rise));
        assign low_w[n] = armed & ~sync_w[n];
        assign int_o[n] = IMPL[n] & eimsk[n] & ((isc == ISC_LOW) ? low_w[n] : eifr[n]);
    end

    always_comb begin
        bus_o = 8'h00;
        if (rd_i && !rst_i) begin
            if (addr_i == A_EICRA)      bus_o = eicra;
            else if (addr_i == A_EICRB) bus_o = eicrb;
            else if (addr_i == A_EIMSK) bus_o = eimsk;
            else if (addr_i == A_EIFR)  bus_o = eifr;
        end
    end

endmodule

// File: tb/tb_atmega_exint.sv
// Self-checking bench for atmega_exint: register table, directed corner cases, random vs sample-history model.
module tb_atmega_exint;

    localparam int S = 2;
    localparam logic [7:0] EICRA = 8'h69, EICRB = 8'h6A, EIMSK = 8'h3D, EIFR = 8'h3C;

    logic       clk = 1'b0;
    logic       rst, wr, rd;
    logic [7:0] addr, bus, pins, ack;
    logic [7:0] bus_o, int_o;
    logic [7:0] bus4;
    logic [3:0] int4;

    always #5 clk = ~clk;

    atmega_exint dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .wr_i(wr), .rd_i(rd),
        .bus_i(bus), .bus_o(bus_o), .pins_i(pins), .int_o(int_o), .int_ack_i(ack)
    );

    atmega_exint #(.PORT_WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .wr_i(wr), .rd_i(rd),
        .bus_i(bus), .bus_o(bus4), .pins_i(pins[3:0]), .int_o(int4), .int_ack_i(ack[3:0])
    );

    int nchk = 0, nerr = 0;

    // Reference model: registers plus the history of pad samples taken since reset.
    logic [7:0] m_eicra = 0, m_eicrb = 0, m_eimsk = 0, m_eifr = 0;
    logic [7:0] smp[$];

    function automatic logic [1:0] m_isc(input int n);
        return (n < 4) ? m_eicra[2*n +: 2] : m_eicrb[2*(n-4) +: 2];
    endfunction

    function automatic logic [7:0] m_int();
        int         N = smp.size();
        logic [7:0] s = (N >= S) ? smp[N-S] : 8'h00;
        logic [7:0] r = 8'h00;
        for (int n = 0; n < 8; n++)
            r[n] = (m_isc(n) == 2'b00) ? ((N >= S) && !s[n]) : m_eifr[n];
        return r & m_eimsk;
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (!rd || rst) return 8'h00;
        case (a)
            EICRA:   return m_eicra;
            EICRB:   return m_eicrb;
            EIMSK:   return m_eimsk;
            EIFR:    return m_eifr;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_edge();
        int         N;
        logic [7:0] s, p, evt;
        if (rst) begin
            m_eicra = 0; m_eicrb = 0; m_eimsk = 0; m_eifr = 0;
            smp.delete();
            return;
        end
        N = smp.size();
        evt = 8'h00;
        if (N >= S + 1) begin
            s = smp[N-S];
            p = smp[N-S-1];
            for (int n = 0; n < 8; n++)
                case (m_isc(n))
                    2'b01:   evt[n] = s[n] != p[n];
                    2'b10:   evt[n] = p[n] && !s[n];
                    2'b11:   evt[n] = !p[n] && s[n];
                    default: evt[n] = 1'b0;
                endcase
        end
        m_eifr = (m_eifr & ~(ack | ((wr && addr == EIFR) ? bus : 8'h00))) | evt;
        if (wr)
            case (addr)
                EICRA:   m_eicra = bus;
                EICRB:   m_eicrb = bus;
                EIMSK:   m_eimsk = bus;
                default: ;
            endcase
        smp.push_back(pins);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #2;
        chk("int_o_model", int_o, m_int());
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        addr = a; bus = d; wr = 1'b1;
        cycle();
        wr = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [7:0] exp);
        addr = a; rd = 1'b1;
        #1;
        chk(nm, bus_o, exp);
        chk({nm, "_model"}, bus_o, m_read(a));
        rd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp8;
        logic [7:0] exp4;
        string      nm;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{EICRA, 8'hA5, 8'hA5, 8'hA5, "tbl_eicra"};
        tbl[1] = '{EICRB, 8'h5A, 8'h5A, 8'h00, "tbl_eicrb"};
        tbl[2] = '{EIMSK, 8'hFF, 8'hFF, 8'h0F, "tbl_eimsk"};
        tbl[3] = '{EIFR,  8'hFF, 8'h00, 8'h00, "tbl_eifr_w1c"};
        tbl[4] = '{8'h55, 8'h77, 8'h00, 8'h00, "tbl_unmapped"};
        tbl[5] = '{EIMSK, 8'h00, 8'h00, 8'h00, "tbl_eimsk0"};
        tbl[6] = '{EICRA, 8'h00, 8'h00, 8'h00, "tbl_eicra0"};
        tbl[7] = '{EICRB, 8'h00, 8'h00, 8'h00, "tbl_eicrb0"};

        rst = 1'b1; wr = 1'b0; rd = 1'b1; addr = EIMSK; bus = 8'h00; pins = 8'hFF; ack = 8'h00;
        idle(2);
        chk("rst_bus_o", bus_o, 8'h00);
        chk("rst_int_o", int_o, 8'h00);
        chk("rst_int4", {4'h0, int4}, 8'h00);
        rd = 1'b0; rst = 1'b0;

        // Pins resting high must not look like a rise after reset.
        wr_reg(EICRA, 8'hFF);
        wr_reg(EICRB, 8'hFF);
        wr_reg(EIMSK, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("noflag_int_o", int_o, 8'h00);
        end
        rd_chk("noflag_eifr", EIFR, 8'h00);

        foreach (tbl[i]) begin
            wr_reg(tbl[i].a, tbl[i].d);
            addr = tbl[i].a; rd = 1'b1;
            #1;
            chk(tbl[i].nm, bus_o, tbl[i].exp8);
            chk({tbl[i].nm, "_w4"}, bus4, tbl[i].exp4);
            rd = 1'b0;
        end

        // Rising edge on pin0: flag and request two cycles after the sampling edge.
        wr_reg(EICRA, 8'h03);
        wr_reg(EIMSK, 8'h01);
        pins = 8'h00;
        idle(4);
        wr_reg(EIFR, 8'hFF);
        pins = 8'h01;
        cycle(); chk("rise_k0", int_o, 8'h00);
        cycle(); chk("rise_k1", int_o, 8'h00);
        cycle(); chk("rise_k2", int_o, 8'h01);
        rd_chk("rise_eifr", EIFR, 8'h01);
        ack = 8'h01;
        cycle();
        ack = 8'h00;
        chk("ack_int_o", int_o, 8'h00);
        rd_chk("ack_eifr", EIFR, 8'h00);

        // Falling edge on pin1 while masked, then unmask and W1C.
        wr_reg(EIMSK, 8'h00);
        wr_reg(EICRA, 8'h08);
        pins = 8'h02;
        idle(4);
        wr_reg(EIFR, 8'hFF);
        pins = 8'h00;
        idle(3);
        rd_chk("fall_eifr", EIFR, 8'h02);
        chk("fall_masked", int_o, 8'h00);
        wr_reg(EIMSK, 8'h02);
        chk("unmask_int_o", int_o, 8'h02);
        wr_reg(EIFR, 8'h02);
        chk("w1c_int_o", int_o, 8'h00);
        rd_chk("w1c_eifr", EIFR, 8'h00);

        // Low-level request on pin2 follows the synchronised pad; ack does nothing.
        pins = 8'hFF;
        idle(3);
        wr_reg(EICRA, 8'h00);
        wr_reg(EIMSK, 8'h04);
        wr_reg(EIFR, 8'hFF);
        idle(2);
        for (int j = 0; j < 9; j++) begin
            pins = (j < 5) ? 8'hFB : 8'hFF;
            ack  = (j == 3) ? 8'h04 : 8'h00;
            cycle();
            chk("low_int_o", int_o, (j >= 1 && j <= 5) ? 8'h04 : 8'h00);
        end
        ack = 8'h00;
        rd_chk("low_eifr", EIFR, 8'h00);

        // Pin1 change arriving on the same edge as a W1C of its flag.
        wr_reg(EICRA, 8'h04);
        wr_reg(EIMSK, 8'h02);
        pins = 8'hFD;
        idle(4);
        wr_reg(EIFR, 8'hFF);
        rd_chk("setwin_pre", EIFR, 8'h00);
        pins = 8'hFF;
        cycle();
        cycle();
        wr_reg(EIFR, 8'h02);
        rd_chk("setwin_eifr", EIFR, 8'h02);
        chk("setwin_int_o", int_o, 8'h02);

        // Narrow instance, unmapped read, reset with a pending flag.
        wr_reg(EICRB, 8'hFF);
        addr = EICRB; rd = 1'b1;
        #1;
        chk("w4_eicrb", bus4, 8'h00);
        rd = 1'b0;
        rd_chk("unmapped_3e", 8'h3E, 8'h00);
        rst = 1'b1;
        cycle();
        chk("rst_mid_int_o", int_o, 8'h00);
        rd_chk("rst_mid_bus", EIFR, 8'h00);
        rst = 1'b0;
        cycle();
        rd_chk("rst_mid_eifr", EIFR, 8'h00);
        rd_chk("rst_mid_eimsk", EIMSK, 8'h00);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            logic [7:0] amap[5];
            amap[0] = EICRA; amap[1] = EICRB; amap[2] = EIMSK; amap[3] = EIFR; amap[4] = 8'h55;
            if ($urandom_range(0, 2) == 0) pins = pins ^ 8'($urandom);
            wr   = ($urandom_range(0, 4) == 0);
            addr = amap[$urandom_range(0, 4)];
            bus  = 8'($urandom);
            ack  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            rst  = ($urandom_range(0, 299) == 0);
            rd   = ($urandom_range(0, 2) == 0);
            #1;
            chk("rand_bus_o", bus_o, m_read(addr));
            cycle();
        end
        rst = 1'b0; wr = 1'b0; rd = 1'b0; ack = 8'h00;
        idle(2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
